// File: rtl/qtree_loader_pkg.sv
// qtree_loader_pkg: shared types and helpers for qtree_stream_loader.
//   - loader_state_e : loader FSM states
//   - ERR_*          : err_code values
//   - pack_node()    : builds an internal-node heap word {0, c[ARITY-1..0], tag}
package qtree_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WAIT_PTR,
    ST_EMIT,
    ST_GO,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
  localparam logic [1:0] ERR_LEFTOVER  = 2'd3;

  // Wide carrier so one function serves any ARITY/PTR_W/TAG_W; callers
  // zero-extend into it and truncate the result to their write width.
  localparam int unsigned PACK_MAX_W = 1024;
  typedef logic [PACK_MAX_W-1:0] pack_vec_t;

  // children holds c[0] in the low PTR_W bits, c[ARITY-1] highest.
  function automatic pack_vec_t pack_node(input pack_vec_t   children,
                                          input pack_vec_t   tag,
                                          input int unsigned tag_w,
                                          input int unsigned arity,
                                          input int unsigned ptr_w);
    pack_vec_t child_mask;
    pack_vec_t tag_mask;
    child_mask = (pack_vec_t'(1) << (arity * ptr_w)) - pack_vec_t'(1);
    tag_mask   = (pack_vec_t'(1) << tag_w) - pack_vec_t'(1);
    return ((children & child_mask) << tag_w) | (tag & tag_mask);
  endfunction

endpackage

// File: rtl/qtree_ptr_stack.sv
// qtree_ptr_stack: DEPTH x PTR_W register stack of heap pointers.
//   clk, reset : clock, synchronous active-high reset (clears sp only)
//   push       : write push_data at stack[sp], sp++
//   push_data  : pointer to push
//   pop        : drop the top ARITY entries, sp -= ARITY
//   sp         : current entry count
//   top_flat   : stack[sp-ARITY+i] in bits [i*PTR_W +: PTR_W], i = 0..ARITY-1
// push and pop are never requested in the same cycle by the loader.
module qtree_ptr_stack
  import qtree_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned PTR_W = 16,
  parameter int unsigned ARITY = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [PTR_W-1:0]             push_data,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic [ARITY*PTR_W-1:0]       top_flat
);

  localparam int unsigned SP_W = $clog2(DEPTH + 1);
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] mem_q [DEPTH];
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [SP_W-1:0]  rd_idx [ARITY];

  always_comb begin
    sp_d = sp_q;
    if (push) begin
      sp_d = sp_q + SP_W'(1);
    end else if (pop) begin
      sp_d = sp_q - SP_W'(ARITY);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[sp_q[AW-1:0]] <= push_data;
    end
  end

  always_comb begin
    top_flat = '0;
    for (int unsigned i = 0; i < ARITY; i++) begin
      rd_idx[i] = sp_q - SP_W'(ARITY) + SP_W'(i);
      top_flat[i*PTR_W +: PTR_W] = mem_q[rd_idx[i][AW-1:0]];
    end
  end

  assign sp = sp_q;

endmodule

// File: rtl/qtree_stream_loader.sv
// qtree_stream_loader: loads postorder-serialised tree tokens into the heap
// and hands the resulting root pointers, then a Go token, to the accelerator.
//   s_*    : token stream in (tdata, tlast = last token of a tree)
//   wr_*   : heap write request (leaf = zero-extended token,
//            node = {0, c[ARITY-1..0], tag})
//   ptr_*  : pointer returned by the heap for the last write
//   root_* : roots[0..NUM_ROOTS-1] in order, with index
//   go_*   : Go token after all roots
//   done   : load complete (terminal until reset)
//   err, err_code : sticky error, only with QTREE_LOADER_ERR_EN defined
//                   (1 overflow, 2 underflow, 3 leftover); otherwise 0.
module qtree_stream_loader
  import qtree_loader_pkg::*;
#(
  parameter int unsigned TOKEN_W   = 67,
  parameter int unsigned TAG_W     = 2,
  parameter int unsigned NODE_TAG  = 2,
  parameter int unsigned ARITY     = 4,
  parameter int unsigned PTR_W     = 16,
  parameter int unsigned WR_W      = 67,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned NUM_ROOTS = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [TOKEN_W-1:0]             s_tdata,
  input  logic                           s_tlast,
  input  logic                           s_tvalid,
  output logic                           s_tready,
  output logic [WR_W-1:0]                wr_data,
  output logic                           wr_valid,
  input  logic                           wr_ready,
  input  logic [PTR_W-1:0]               ptr_data,
  input  logic                           ptr_valid,
  output logic                           ptr_ready,
  output logic [PTR_W-1:0]               root_data,
  output logic [$clog2(NUM_ROOTS):0]     root_idx,
  output logic                           root_valid,
  input  logic                           root_ready,
  output logic                           go_valid,
  input  logic                           go_ready,
  output logic                           done,
  output logic                           err,
  output logic [1:0]                     err_code
);

  localparam int unsigned SP_W = $clog2(DEPTH + 1);
  localparam int unsigned RI_W = $clog2(NUM_ROOTS) + 1;
  localparam int unsigned RA_W = (NUM_ROOTS > 1) ? $clog2(NUM_ROOTS) : 1;

`ifdef QTREE_LOADER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  loader_state_e    state_q, state_d;
  logic [WR_W-1:0]  wr_data_q, wr_data_d;
  logic             tlast_q, tlast_d;
  logic [RI_W-1:0]  root_cnt_q, root_cnt_d;
  logic [RI_W-1:0]  emit_idx_q, emit_idx_d;
  logic [PTR_W-1:0] roots_q [NUM_ROOTS];
  logic [PTR_W-1:0] roots_d [NUM_ROOTS];
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic                   push, pop;
  logic [SP_W-1:0]        sp;
  logic [ARITY*PTR_W-1:0] top_flat;
  logic                   is_node;
  logic [1:0]             chk_code;
  logic [WR_W-1:0]        node_word;

  qtree_ptr_stack #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .ARITY (ARITY)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (ptr_data),
    .pop       (pop),
    .sp        (sp),
    .top_flat  (top_flat)
  );

  assign is_node   = (s_tdata[TAG_W-1:0] == TAG_W'(NODE_TAG));
  assign node_word = WR_W'(pack_node(pack_vec_t'(top_flat),
                                     pack_vec_t'(s_tdata[TAG_W-1:0]),
                                     TAG_W, ARITY, PTR_W));

  // Stack-discipline check of the token being offered; the leftover test
  // looks at the stack as it will be once this token's pointer is placed
  // (a tlast pointer goes to root storage, so nothing may remain).
  always_comb begin
    chk_code = ERR_NONE;
    if (!is_node && sp == SP_W'(DEPTH)) begin
      chk_code = ERR_OVERFLOW;
    end else if (s_tlast && root_cnt_q >= RI_W'(NUM_ROOTS)) begin
      chk_code = ERR_OVERFLOW;
    end else if (is_node && sp < SP_W'(ARITY)) begin
      chk_code = ERR_UNDERFLOW;
    end else if (s_tlast && (is_node ? (sp != SP_W'(ARITY)) : (sp != '0))) begin
      chk_code = ERR_LEFTOVER;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_data_d  = wr_data_q;
    tlast_d    = tlast_q;
    root_cnt_d = root_cnt_q;
    emit_idx_d = emit_idx_q;
    roots_d    = roots_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    push       = 1'b0;
    pop        = 1'b0;
    s_tready   = 1'b0;
    wr_valid   = 1'b0;
    ptr_ready  = 1'b0;
    root_valid = 1'b0;
    go_valid   = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (root_cnt_q >= RI_W'(NUM_ROOTS)) begin
          state_d = ST_EMIT;
        end else begin
          s_tready = !reset;
          if (s_tvalid && s_tready) begin
            if (ERR_EN && chk_code != ERR_NONE) begin
              state_d    = ST_ERROR;
              err_d      = 1'b1;
              err_code_d = chk_code;
            end else begin
              state_d   = ST_WRITE;
              tlast_d   = s_tlast;
              pop       = is_node;
              wr_data_d = is_node ? node_word : WR_W'(s_tdata);
            end
          end
        end
      end
      ST_WRITE: begin
        wr_valid = 1'b1;
        if (wr_ready) state_d = ST_WAIT_PTR;
      end
      ST_WAIT_PTR: begin
        ptr_ready = 1'b1;
        if (ptr_valid) begin
          state_d = ST_IDLE;
          if (tlast_q) begin
            roots_d[root_cnt_q[RA_W-1:0]] = ptr_data;
            root_cnt_d = root_cnt_q + RI_W'(1);
          end else begin
            push = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        root_valid = 1'b1;
        if (root_ready) begin
          if (emit_idx_q == RI_W'(NUM_ROOTS - 1)) begin
            state_d = ST_GO;
          end else begin
            emit_idx_d = emit_idx_q + RI_W'(1);
          end
        end
      end
      ST_GO: begin
        go_valid = 1'b1;
        if (go_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      ST_ERROR: begin
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_data_q  <= '0;
      tlast_q    <= 1'b0;
      root_cnt_q <= '0;
      emit_idx_q <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      for (int unsigned i = 0; i < NUM_ROOTS; i++) begin
        roots_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wr_data_q  <= wr_data_d;
      tlast_q    <= tlast_d;
      root_cnt_q <= root_cnt_d;
      emit_idx_q <= emit_idx_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      roots_q    <= roots_d;
    end
  end

  assign wr_data   = wr_data_q;
  assign root_data = roots_q[emit_idx_q[RA_W-1:0]];
  assign root_idx  = emit_idx_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_qtree_stream_loader.sv
module tb_qtree_stream_loader;

  localparam int TOKEN_W   = 67;
  localparam int PTR_W     = 16;
  localparam int WR_W      = 67;
  localparam int NUM_ROOTS = 2;
  localparam int RI_W      = 2;
  localparam int CW        = 67;

  logic               clk = 1'b0;
  logic               reset;
  logic [TOKEN_W-1:0] s_tdata;
  logic               s_tlast, s_tvalid, s_tready;
  logic [WR_W-1:0]    wr_data;
  logic               wr_valid, wr_ready;
  logic [PTR_W-1:0]   ptr_data;
  logic               ptr_valid, ptr_ready;
  logic [PTR_W-1:0]   root_data;
  logic [RI_W-1:0]    root_idx;
  logic               root_valid, root_ready;
  logic               go_valid, go_ready, done, err;
  logic [1:0]         err_code;

  always #5 clk = ~clk;

  qtree_stream_loader #(
    .TOKEN_W(67), .TAG_W(2), .NODE_TAG(2), .ARITY(4), .PTR_W(16),
    .WR_W(67), .DEPTH(256), .NUM_ROOTS(2)
  ) dut (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .ptr_data(ptr_data), .ptr_valid(ptr_valid), .ptr_ready(ptr_ready),
    .root_data(root_data), .root_idx(root_idx), .root_valid(root_valid), .root_ready(root_ready),
    .go_valid(go_valid), .go_ready(go_ready), .done(done),
    .err(err), .err_code(err_code)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int               scen;
    logic [TOKEN_W-1:0] tdata;
    logic             tlast;
    logic [WR_W-1:0]  exp_wr;
    int               wr_stall;
    int               ptr_stall;
    logic [PTR_W-1:0] exp_root;
  } vec_t;

  typedef struct {
    logic [PTR_W-1:0] ptr;
    logic [RI_W-1:0]  idx;
  } root_exp_t;

  vec_t             tbl [8];
  logic [WR_W-1:0]  wr_sb [$];
  root_exp_t        root_sb [$];
  logic [PTR_W-1:0] heap_next;
  int               roots_pushed;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, CW'(act), CW'(exp));
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    wr_ready = 1'b0; ptr_valid = 1'b0; ptr_data = '0;
    root_ready = 1'b0; go_ready = 1'b0;
    tick(); tick();
    chk1("rst_s_tready", s_tready, 1'b0);
    chk1("rst_wr_valid", wr_valid, 1'b0);
    chk1("rst_ptr_ready", ptr_ready, 1'b0);
    chk1("rst_root_valid", root_valid, 1'b0);
    chk1("rst_go_valid", go_valid, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk("rst_err_code", CW'(err_code), CW'(0));
    reset = 1'b0;
    tick();
    chk1("idle_s_tready", s_tready, 1'b1);
    heap_next = 16'h10;
    roots_pushed = 0;
    wr_sb.delete();
    root_sb.delete();
  endtask

  task automatic send_token(input logic [TOKEN_W-1:0] tdata, input logic tlast,
                            input logic [WR_W-1:0] exp_wr, input logic [PTR_W-1:0] exp_root,
                            input int wr_stall, input int ptr_stall);
    int n;
    root_exp_t re;
    logic [WR_W-1:0] exp;
    wr_sb.push_back(exp_wr);
    if (tlast) begin
      re.ptr = exp_root;
      re.idx = RI_W'(roots_pushed);
      roots_pushed++;
      root_sb.push_back(re);
    end
    s_tdata = tdata; s_tlast = tlast; s_tvalid = 1'b1;
    n = 0;
    while (!s_tready && n < 20) begin tick(); n++; end
    if (!s_tready) begin
      timeout("s_tready");
      s_tvalid = 1'b0;
      return;
    end
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    chk1("wr_valid_t1", wr_valid, 1'b1);
    for (int k = 0; k < wr_stall; k++) begin
      chk1("stall_wr_valid", wr_valid, 1'b1);
      chk("stall_wr_data", CW'(wr_data), CW'(wr_sb[0]));
      chk1("stall_s_tready", s_tready, 1'b0);
      chk1("stall_ptr_ready", ptr_ready, 1'b0);
      // stray pointer while not waiting for one: must be ignored
      ptr_valid = (k == 0);
      ptr_data  = 16'hDEAD;
      tick();
    end
    ptr_valid = 1'b0;
    wr_ready = 1'b1;
    if (!wr_valid) begin
      timeout("wr_valid");
    end else begin
      exp = wr_sb.pop_front();
      chk("wr_data", CW'(wr_data), CW'(exp));
    end
    tick();
    wr_ready = 1'b0;
    chk1("wait_ptr_ready", ptr_ready, 1'b1);
    for (int k = 0; k < ptr_stall; k++) begin
      chk1("ptrwait_s_tready", s_tready, 1'b0);
      chk1("ptrwait_ptr_ready", ptr_ready, 1'b1);
      chk1("ptrwait_wr_valid", wr_valid, 1'b0);
      tick();
    end
    ptr_valid = 1'b1; ptr_data = heap_next;
    tick();
    ptr_valid = 1'b0;
    heap_next = heap_next + 16'h1;
    chk1("post_ptr_s_tready", s_tready, roots_pushed < NUM_ROOTS);
  endtask

  task automatic run_emit(input int stall);
    int n;
    root_exp_t re;
    root_ready = 1'b0;
    n = 0;
    while (!root_valid && n < 10) begin tick(); n++; end
    if (!root_valid) begin
      timeout("root_valid");
      return;
    end
    for (int k = 0; k < stall; k++) begin
      chk("hold_root_data", CW'(root_data), CW'(root_sb[0].ptr));
      chk("hold_root_idx", CW'(root_idx), CW'(root_sb[0].idx));
      chk1("hold_go_valid", go_valid, 1'b0);
      tick();
    end
    root_ready = 1'b1;
    for (int r = 0; r < NUM_ROOTS; r++) begin
      n = 0;
      while (!root_valid && n < 10) begin tick(); n++; end
      if (!root_valid || root_sb.size() == 0) begin
        timeout("root_handshake");
      end else begin
        re = root_sb.pop_front();
        chk("root_data", CW'(root_data), CW'(re.ptr));
        chk("root_idx", CW'(root_idx), CW'(re.idx));
        chk1("go_early", go_valid, 1'b0);
      end
      tick();
    end
    root_ready = 1'b0;
    chk("root_sb_left", CW'(root_sb.size()), CW'(0));
    chk("wr_sb_left", CW'(wr_sb.size()), CW'(0));
    chk1("go_root_valid", root_valid, 1'b0);
    chk1("go_valid", go_valid, 1'b1);
    chk1("go_done", done, 1'b0);
    tick();
    chk1("go_valid_held", go_valid, 1'b1);
    go_ready = 1'b1;
    tick();
    go_ready = 1'b0;
    chk1("done", done, 1'b1);
    chk1("done_go_valid", go_valid, 1'b0);
    chk1("done_s_tready", s_tready, 1'b0);
  endtask

  task automatic run_scen(input int s);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].scen == s)
        send_token(tbl[i].tdata, tbl[i].tlast, tbl[i].exp_wr, tbl[i].exp_root,
                   tbl[i].wr_stall, tbl[i].ptr_stall);
    end
    run_emit((s == 1) ? 4 : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [WR_W-1:0] node_exp;
    node_exp = '0;
    node_exp[65:50] = 16'h13;
    node_exp[49:34] = 16'h12;
    node_exp[33:18] = 16'h11;
    node_exp[17:2]  = 16'h10;
    node_exp[1:0]   = 2'd2;

    // scenario 0: two leaf-only trees (tags 1 and 0)
    tbl[0] = '{0, 67'h4_0123_4567_89AB_CDE5, 1'b1, 67'h4_0123_4567_89AB_CDE5, 0, 0, 16'h10};
    tbl[1] = '{0, 67'h2_FEDC_BA98_7654_3210, 1'b1, 67'h2_FEDC_BA98_7654_3210, 0, 0, 16'h11};
    // scenario 1: 4 leaves + node (upper token bits must not leak), then a leaf tree
    tbl[2] = '{1, 67'h0_0000_0000_0000_00A1, 1'b0, 67'h0_0000_0000_0000_00A1, 0, 0, 16'h0};
    tbl[3] = '{1, 67'h0_0000_0000_0000_00B3, 1'b0, 67'h0_0000_0000_0000_00B3, 5, 3, 16'h0};
    tbl[4] = '{1, 67'h0_0000_0000_0000_00C4, 1'b0, 67'h0_0000_0000_0000_00C4, 0, 0, 16'h0};
    tbl[5] = '{1, 67'h0_0000_0000_0000_00D5, 1'b0, 67'h0_0000_0000_0000_00D5, 0, 0, 16'h0};
    tbl[6] = '{1, 67'h7_FFFF_FFFF_FFFF_FFFE, 1'b1, node_exp, 0, 0, 16'h14};
    tbl[7] = '{1, 67'h0_0000_0000_0000_0043, 1'b1, 67'h0_0000_0000_0000_0043, 0, 0, 16'h15};

    run_scen(0);
    run_scen(1);

`ifdef QTREE_LOADER_ERR_EN
    // node as first token: underflow, nothing written
    do_reset();
    s_tdata = 67'h2; s_tlast = 1'b0; s_tvalid = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk1("uf_err", err, 1'b1);
      chk("uf_err_code", CW'(err_code), CW'(2));
      chk1("uf_wr_valid", wr_valid, 1'b0);
      chk1("uf_s_tready", s_tready, 1'b0);
      tick();
    end
    s_tvalid = 1'b0;

    // two leaves, second closes the tree with one pointer left on the stack
    do_reset();
    send_token(67'h5, 1'b0, 67'h5, 16'h0, 0, 0);
    s_tdata = 67'h9; s_tlast = 1'b1; s_tvalid = 1'b1;
    chk1("lo_s_tready", s_tready, 1'b1);
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    chk1("lo_err", err, 1'b1);
    chk("lo_err_code", CW'(err_code), CW'(3));
    chk1("lo_wr_valid", wr_valid, 1'b0);
    chk1("lo_s_tready", s_tready, 1'b0);
    run_scen(0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qtree_stream_loader.md
# qtree_stream_loader

Parametrised AXI-stream-to-heap tree loader. It accepts postorder-serialised tree tokens and writes each node to the heap allocator through a valid/ready write port, collecting the returned pointer. Child pointers are kept on an internal stack, and the pointer of each completed tree is captured as a root. Once the configured number of roots has been loaded, the roots and then a Go token are handed to the accelerator's argument inputs. It is the generic successor of the per-design hand-written input wrappers: one instance per input tree type, any arity, depth, width or root count.

## Interface
- TOKEN_W, 67: input token width.
- TAG_W, 2: constructor tag field, `tdata[TAG_W-1:0]`.
- NODE_TAG, 2: tag value of an internal node; every other tag is a leaf.
- ARITY, 4: children per internal node.
- PTR_W, 16: heap pointer width.
- WR_W, 67: heap write width; must be ≥ TOKEN_W and ≥ TAG_W+ARITY*PTR_W.
- DEPTH, 256: pointer-stack entries.
- NUM_ROOTS, 2: trees per load (≥1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- s_tdata  in  TOKEN_W  token.
- s_tlast  in  1  last token of the current tree.
- s_tvalid  in  1  token valid.
- s_tready  out  1  token accepted.
- wr_data  out  WR_W  heap write payload.
- wr_valid  out  1  write request.
- wr_ready  in  1  write accepted.
- ptr_data  in  PTR_W  allocated pointer.
- ptr_valid  in  1  pointer valid.
- ptr_ready  out  1  pointer accepted.
- root_data  out  PTR_W  root pointer.
- root_idx  out  $clog2(NUM_ROOTS)+1  root index.
- root_valid  out  1  root pointer valid.
- root_ready  in  1  root pointer accepted.
- go_valid  out  1  Go token valid.
- go_ready  in  1  Go token accepted.
- done  out  1  load complete.
- err  out  1  sticky error (`QTREE_LOADER_ERR_EN` only).
- err_code  out  2  error code: 1 overflow, 2 underflow, 3 leftover (`QTREE_LOADER_ERR_EN` only).

## Operation
- States and transitions:
  - IDLE → WRITE on s_tvalid&&s_tready.
  - WRITE → WAIT_PTR on wr_ready.
  - WAIT_PTR → IDLE on ptr_valid.
  - IDLE → EMIT when root_cnt==NUM_ROOTS.
  - EMIT → GO after the last root handshake.
  - GO → DONE on go_ready.
  - DONE is terminal until reset.
  - ERROR is terminal until reset.
- s_tready=1 only in IDLE with root_cnt<NUM_ROOTS.
- On token accept, the token and tlast are registered and wr_data is built:
  - Leaf: wr_data = zero-extended token.
  - Node: wr_data = {0, c[ARITY-1]…c[0], tag}.
  - c[i] = stack[sp-ARITY+i], so c[0] is the earliest-serialised child, in bits [TAG_W+PTR_W-1:TAG_W].
  - Node: sp -= ARITY.
- ptr_ready=1 in WAIT_PTR only. On ptr handshake, ptr_data is pushed: stack[sp] = ptr, sp++.
- If the registered tlast is set, the pushed pointer is instead popped straight into roots[root_cnt], and root_cnt increments. The stack must hold zero entries afterwards.
- EMIT presents roots[0..NUM_ROOTS-1] in order on root_data/root_idx. The index advances on each root_valid&&root_ready.
- In GO, go_valid=1 until go_ready. Then done=1.
- sp width is $clog2(DEPTH+1). root_cnt width matches root_idx.

## Timing
- Reset values: s_tready=0 in the reset cycle (IDLE the cycle after); wr_valid=0; ptr_ready=0; root_valid=0; go_valid=0; done=0; err=0; err_code=0; sp=0; root_cnt=0. Stack contents are don't-care.
- Token accepted at cycle t → wr_valid registered high at t+1.
- wr_data is stable while wr_valid is high and not ready.
- ptr_data is accepted in the same cycle that ptr_valid is seen in WAIT_PTR.
- IDLE is re-entered the next cycle. Minimum 3 cycles per token.
- ptr_valid outside WAIT_PTR is ignored.
- The last root handshake and go_valid are at least one cycle apart.
- Reset mid-operation abandons any outstanding write or pointer.

## Configuration
- `QTREE_LOADER_ERR_EN` defined — errors are checked at token accept:
  - Overflow: a leaf with sp==DEPTH, or a tlast token with root storage full.
  - Underflow: a node with sp<ARITY.
  - Leftover: tlast with a non-empty stack after the push.
  - On any error: the token is not written, ERROR is entered, err=1 with err_code, and s_tready=0 permanently.
- Undefined — no checks are made, err/err_code are tied 0, and sp wraps modulo 2^width (behaviour undefined).

## Structure
- Package `qtree_loader_pkg`:
  - loader state enum.
  - error-code localparams.
  - a wr_data packing function parametrised by ARITY/PTR_W.
- Sub-module `qtree_ptr_stack`: DEPTH×PTR_W register stack with push, multi-pop of ARITY, and a parallel read of the top ARITY entries.

## Test plan
All scenarios use the defaults, NODE_TAG=2, and a heap model returning pointers 0x10, 0x11, … in order.
- Leaf-only trees: leaf tag 1 with tlast, then leaf tag 0 with tlast → roots 0x10 and 0x11 emitted with idx 0 and 1, then go_valid, then done=1.
- Tree 1: 4 leaves then a node with tlast → node wr_data fields c0..c3 = 0x10..0x13, root0=0x14. Tree 2: leaf with tlast → root1=0x15.
- wr_ready held low 5 cycles, ptr_valid delayed 3 cycles → wr_data stable, s_tready=0 throughout, no token lost.
- root_ready low 4 cycles in EMIT → root_data/root_idx held; go_valid not asserted early.
- `QTREE_LOADER_ERR_EN`: node as first token → err=1, err_code=2, wr_valid never asserts.
- `QTREE_LOADER_ERR_EN`: 2 leaves, second with tlast → err_code=3. Reset then clears err, and a legal stream completes.
